// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - write-back and register-read signal bundle for wb_regfile
interface wb_regfile_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  reg_write_in;
  logic                  mem_to_reg_in;
  logic [7:0]            ALU_result_in;
  logic [7:0]            read_data_in;
  logic [REG_ADDR_W-1:0] rd_in;
  logic [REG_ADDR_W-1:0] rs1_addr;
  logic [REG_ADDR_W-1:0] rs2_addr;
  logic [7:0]            rs1_data;
  logic [7:0]            rs2_data;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [7:0]            wb_data;
  logic                  wb_valid_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;
  logic [7:0]            wb_data_q;
  logic [15:0]           write_count;

  modport master (
    output reg_write_in, mem_to_reg_in, ALU_result_in, read_data_in, rd_in,
    output rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_valid, wb_rd, wb_data,
    input  wb_valid_q, wb_rd_q, wb_data_q, write_count
  );

  modport slave (
    input  reg_write_in, mem_to_reg_in, ALU_result_in, read_data_in, rd_in,
    input  rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_valid, wb_rd, wb_data,
    output wb_valid_q, wb_rd_q, wb_data_q, write_count
  );
endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - 8-bit register file with write-back stage, write-through bypass
// and a one-cycle registered copy of the write-back for second-level forwarding.
module wb_regfile #(
  parameter int REG_ADDR_W = 5,
  parameter int REG_COUNT  = 32
) (
  input  logic        clock,
  input  logic        reset,
  wb_regfile_if.slave bus
);
  logic [7:0]  regs [REG_COUNT];
  logic [7:0]  wb_data;
  logic        wb_valid;
  logic [7:0]  rs1_stored;
  logic [7:0]  rs2_stored;
  logic [15:0] write_count;

  always_comb begin
    wb_data  = bus.mem_to_reg_in ? bus.read_data_in : bus.ALU_result_in;
    // Index 0 is hardwired; reset also kills the write so bypass stays off.
    wb_valid = bus.reg_write_in && (bus.rd_in != '0) && !reset;
  end

  always_comb begin
    rs1_stored = (bus.rs1_addr == '0) ? 8'h00 : regs[bus.rs1_addr];
    rs2_stored = (bus.rs2_addr == '0) ? 8'h00 : regs[bus.rs2_addr];
    bus.rs1_data = (wb_valid && bus.rs1_addr == bus.rd_in) ? wb_data : rs1_stored;
    bus.rs2_data = (wb_valid && bus.rs2_addr == bus.rd_in) ? wb_data : rs2_stored;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= 8'h00;
      end
      bus.wb_valid_q <= 1'b0;
      bus.wb_rd_q    <= '0;
      bus.wb_data_q  <= 8'h00;
      write_count    <= 16'h0000;
    end else begin
      if (wb_valid) begin
        regs[bus.rd_in] <= wb_data;
        write_count     <= write_count + 16'd1;
      end
      bus.wb_valid_q <= wb_valid;
      bus.wb_rd_q    <= bus.rd_in;
      bus.wb_data_q  <= wb_data;
    end
  end

  assign bus.wb_valid    = wb_valid;
  assign bus.wb_rd       = bus.rd_in;
  assign bus.wb_data     = wb_data;
  assign bus.write_count = write_count;
endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed scoreboard bench for wb_regfile
module tb_wb_regfile;
  localparam int AW = 5;

  typedef struct {
    string       tag;
    logic [15:0] value;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  wb_regfile_if #(.REG_ADDR_W(AW)) bus ();

  wb_regfile #(.REG_ADDR_W(AW), .REG_COUNT(32)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [15:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic check_next(input logic [15:0] observed);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h expected=none", observed);
    end else begin
      e = sb.pop_front();
      assert (observed === e.value) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, observed, e.value);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [7:0] alu,
                       input logic [7:0] rdata, input logic [AW-1:0] rd);
    bus.reg_write_in  = we;
    bus.mem_to_reg_in = m2r;
    bus.ALU_result_in = alu;
    bus.read_data_in  = rdata;
    bus.rd_in         = rd;
    #1;
  endtask

  task automatic read_reg(input logic [AW-1:0] a, input string tag, input logic [7:0] exp);
    bus.rs1_addr = a;
    #1;
    expect_val(tag, {8'h00, exp});
    check_next({8'h00, bus.rs1_data});
  endtask

  initial begin
    bus.reg_write_in  = 1'b0;
    bus.mem_to_reg_in = 1'b0;
    bus.ALU_result_in = 8'h00;
    bus.read_data_in  = 8'h00;
    bus.rd_in         = '0;
    bus.rs1_addr      = '0;
    bus.rs2_addr      = '0;

    // Reset for two edges with a write pending: it must be dropped.
    rst = 1'b1;
    drive(1'b1, 1'b0, 8'hAB, 8'h00, 5'd3);
    expect_val("wb_valid_in_reset", 16'd0);
    check_next({15'd0, bus.wb_valid});
    tick();
    tick();
    expect_val("reset_write_count", 16'd0);
    check_next(bus.write_count);
    expect_val("reset_wb_valid_q", 16'd0);
    check_next({15'd0, bus.wb_valid_q});
    expect_val("reset_wb_data_q", 16'd0);
    check_next({8'd0, bus.wb_data_q});
    read_reg(5'd3, "reset_reg3", 8'h00);

    // First write commits on the first edge after reset release.
    rst = 1'b0;
    drive(1'b1, 1'b0, 8'h5A, 8'h00, 5'd3);
    expect_val("wb_valid_first", 16'd1);
    check_next({15'd0, bus.wb_valid});
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 5'd0);
    read_reg(5'd3, "reg3_after_write", 8'h5A);
    expect_val("count_after_first", 16'd1);
    check_next(bus.write_count);
    expect_val("wb_rd_q_first", 16'd3);
    check_next({11'd0, bus.wb_rd_q});
    expect_val("wb_data_q_first", 16'h5A);
    check_next({8'd0, bus.wb_data_q});
    expect_val("wb_valid_q_first", 16'd1);
    check_next({15'd0, bus.wb_valid_q});

    // Load path with both read ports bypassing the same destination.
    bus.rs1_addr = 5'd7;
    bus.rs2_addr = 5'd7;
    drive(1'b1, 1'b1, 8'h11, 8'hC3, 5'd7);
    expect_val("bypass_rs1", 16'hC3);
    check_next({8'd0, bus.rs1_data});
    expect_val("bypass_rs2", 16'hC3);
    check_next({8'd0, bus.rs2_data});
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 5'd0);
    read_reg(5'd7, "reg7_after_load", 8'hC3);
    expect_val("rs2_reg7_stored", 16'hC3);
    check_next({8'd0, bus.rs2_data});

    // Writes to register 0 are discarded and not counted.
    bus.rs1_addr = 5'd0;
    drive(1'b1, 1'b0, 8'hFF, 8'h00, 5'd0);
    expect_val("wb_valid_rd0", 16'd0);
    check_next({15'd0, bus.wb_valid});
    expect_val("rs1_rd0_no_bypass", 16'd0);
    check_next({8'd0, bus.rs1_data});
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 5'd0);
    read_reg(5'd0, "reg0_after_write", 8'h00);
    expect_val("count_after_rd0", 16'd2);
    check_next(bus.write_count);

    // Back-to-back writes to the same register.
    drive(1'b1, 1'b0, 8'h10, 8'h00, 5'd5);
    tick();
    expect_val("wb_data_q_0x10", 16'h10);
    check_next({8'd0, bus.wb_data_q});
    drive(1'b1, 1'b0, 8'h20, 8'h00, 5'd5);
    tick();
    expect_val("wb_data_q_0x20", 16'h20);
    check_next({8'd0, bus.wb_data_q});
    drive(1'b0, 1'b0, 8'h77, 8'h00, 5'd3);
    read_reg(5'd5, "reg5_last_value", 8'h20);
    expect_val("count_after_b2b", 16'd4);
    check_next(bus.write_count);

    // Write enable low: no commit regardless of other inputs.
    tick();
    read_reg(5'd3, "reg3_we_low", 8'h5A);
    expect_val("count_we_low", 16'd4);
    check_next(bus.write_count);

    // Mid-stream reset drops the pending write and clears state.
    drive(1'b1, 1'b0, 8'h44, 8'h00, 5'd9);
    tick();
    rst = 1'b1;
    drive(1'b1, 1'b0, 8'h99, 8'h00, 5'd9);
    read_reg(5'd9, "reg9_no_bypass_in_reset", 8'h44);
    tick();
    read_reg(5'd9, "reg9_after_reset", 8'h00);
    expect_val("count_after_reset", 16'd0);
    check_next(bus.write_count);
    expect_val("wb_valid_q_after_reset", 16'd0);
    check_next({15'd0, bus.wb_valid_q});

    // Counter wrap: 65535 writes reach 0xFFFF, one more wraps to 0.
    rst = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 1'b0, 8'(i), 8'h00, 5'd1);
      tick();
    end
    expect_val("count_ffff", 16'hFFFF);
    check_next(bus.write_count);
    drive(1'b1, 1'b0, 8'hE1, 8'h00, 5'd1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 5'd0);
    expect_val("count_wrap", 16'h0000);
    check_next(bus.write_count);
    read_reg(5'd1, "reg1_last_wrap_write", 8'hE1);

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, meaning register index width.
REQ-002 SHALL have parameter REG_COUNT, default 32, meaning number of 8-bit architectural registers (2**REG_ADDR_W).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port reg_write_in  input  1  write-back enable from the MEM/WB register.
REQ-006 SHALL have port mem_to_reg_in  input  1  1 selects read_data_in, 0 selects ALU_result_in.
REQ-007 SHALL have port ALU_result_in  input  8  ALU result from the MEM/WB register.
REQ-008 SHALL have port read_data_in  input  8  load data from the MEM/WB register.
REQ-009 SHALL have port rd_in  input  REG_ADDR_W  destination register index.
REQ-010 SHALL have ports rs1_addr and rs2_addr  input  REG_ADDR_W  read port indices from decode.
REQ-011 SHALL have ports rs1_data and rs2_data  output  8  read port data.
REQ-012 SHALL have ports wb_valid (1), wb_rd (REG_ADDR_W), wb_data (8)  output  combinational current write-back, for EX forwarding.
REQ-013 SHALL have ports wb_valid_q (1), wb_rd_q (REG_ADDR_W), wb_data_q (8)  output  registered previous write-back, for second-level forwarding.
REQ-014 SHALL have port write_count  output  16  number of committed register writes.

Function
REQ-015 wb_data SHALL equal read_data_in when mem_to_reg_in=1, else ALU_result_in.
REQ-016 wb_valid SHALL equal reg_write_in AND (rd_in != 0) AND NOT reset; wb_rd SHALL equal rd_in.
REQ-017 On a rising edge with wb_valid=1, register[rd_in] SHALL take wb_data; no other register changes.
REQ-018 Register 0 SHALL always read 0; writes to index 0 SHALL be discarded and SHALL NOT count.
REQ-019 Reads SHALL be combinational: rsN_data = register[rsN_addr] when no bypass applies.
REQ-020 Write-through bypass: when wb_valid=1 and rsN_addr=rd_in, rsN_data SHALL equal wb_data in the same cycle.
REQ-021 Both read ports SHALL bypass independently; rs1_addr=rs2_addr=rd_in SHALL return wb_data on both.
REQ-022 wb_valid_q/wb_rd_q/wb_data_q SHALL capture wb_valid/wb_rd/wb_data each rising edge (latency 1 cycle).
REQ-023 write_count SHALL increment by 1 on each edge where wb_valid=1; wraps 0xFFFF -> 0x0000.
REQ-024 Back-to-back writes to the same rd SHALL each commit in order; the last value persists.
REQ-025 reg_write_in=0 SHALL leave all state except the wb_*_q pipeline unchanged, regardless of other inputs.

Reset
REQ-026 While reset=1 at a rising edge, all registers, wb_valid_q, wb_rd_q, wb_data_q and write_count SHALL become 0.
REQ-027 A write presented in a reset cycle SHALL be dropped (wb_valid forced 0), including mid-stream reset.
REQ-028 Reset deasserted: first write SHALL commit on the first edge with reset=0.
REQ-029 During reset, bypass SHALL be inactive; reads SHALL return stored contents (0 after first reset edge).

Verification
REQ-030 Reset 2 cycles, then reg_write_in=1, mem_to_reg_in=0, ALU_result_in=0x5A, rd_in=3 -> after edge, rs1_addr=3 reads 0x5A, write_count=1, wb_rd_q=3, wb_data_q=0x5A.
REQ-031 mem_to_reg_in=1, read_data_in=0xC3, ALU_result_in=0x11, rd_in=7, rs1_addr=rs2_addr=7 same cycle -> rs1_data=rs2_data=0xC3 before edge; register 7=0xC3 after.
REQ-032 reg_write_in=1, rd_in=0, ALU_result_in=0xFF -> wb_valid=0, rs1_addr=0 reads 0x00, write_count unchanged.
REQ-033 Writes 0x10 then 0x20 to rd_in=5 on consecutive cycles -> register 5=0x20, write_count +2, wb_data_q tracks 0x10 then 0x20.
REQ-034 Register 9=0x44; reset=1 with reg_write_in=1, rd_in=9, ALU_result_in=0x99 -> after edge register 9=0, write_count=0, wb_valid_q=0.
REQ-035 Preload write_count=0xFFFF via 65535 writes plus one -> write_count=0x0000 after 65536th write.
